// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction fetch slice.
package fetch_pkg;

  localparam int FETCH_W = 32;
  localparam int INST_W  = 32;

  typedef struct packed {
    logic [FETCH_W-1:0] pc;
    logic [INST_W-1:0]  inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Valid/ready handshake carrying {pc, inst} from fetch to decode.
interface fetch_if;
  import fetch_pkg::*;

  logic               out_valid;
  logic [INST_W-1:0]  out_inst;
  logic [FETCH_W-1:0] out_pc;
  logic               out_ready;

  modport master (
    output out_valid, out_inst, out_pc,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_inst, out_pc,
    output out_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries with flush; head reads 0 when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  fetch_entry_t  mem [DEPTH];

  logic do_pop;
  logic do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset: head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns fetch_pc, feeds the prefetch FIFO, handles redirects.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int                 DEPTH    = 4,
  parameter logic [FETCH_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [FETCH_W-1:0] mem_addr,
  input  logic [INST_W-1:0]  mem_inst,
  input  logic               mem_ready,
  fetch_if.master            dec,
  input  logic               branch_taken,
  input  logic [FETCH_W-1:0] branch_addr
);

  logic [FETCH_W-1:0] fetch_pc;
  logic               full;
  logic               empty;
  logic               pop;
  logic               push;
  fetch_entry_t       din;
  fetch_entry_t       head;

  assign mem_addr = fetch_pc;
  assign pop      = dec.out_valid & dec.out_ready & ~branch_taken;
  assign push     = mem_ready & ~branch_taken & (~full | pop);
  assign din      = '{pc: fetch_pc, inst: mem_inst};

  assign dec.out_valid = ~empty;
  assign dec.out_pc    = head.pc;
  assign dec.out_inst  = head.inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (branch_taken) begin
      fetch_pc <= branch_addr & ~FETCH_W'(3);
    end else if (push) begin
      fetch_pc <= fetch_pc + FETCH_W'(4);
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (branch_taken),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

endmodule
